// File: rtl/adt7311_reader.sv
// adt7311_reader: polls an ADT7311 over SPI mode 3; optional OVERTEMP hysteresis alarm under BUBBLEDRIVE_TEMP_ALARM_EN
module adt7311_reader #(
  parameter int          CLKDIV     = 12,
  parameter int          POLLCYCLES = 4800000,
  parameter int          INITCYCLES = 24000,
  parameter logic [12:0] ALARMHI    = 13'd1120,
  parameter logic [12:0] ALARMLO    = 13'd1040
) (
  input  logic        MCLK,
  input  logic        nRESET,
  output logic        nTEMPCS,
  output logic        TEMPMOSI,
  input  logic        TEMPMISO,
  output logic        TEMPCLK,
  output logic [12:0] TEMPDATA,
  output logic        TEMPVALID,
  output logic        OVERTEMP
);
  typedef enum logic [2:0] {RSTSEQ, INITWAIT, POLLWAIT, CMD, DATA, LATCH} state_t;
  localparam int DW = $clog2(CLKDIV);
  localparam int CW = $clog2((POLLCYCLES > INITCYCLES ? POLLCYCLES : INITCYCLES) + 1);
  localparam logic [DW-1:0] DMAX = DW'(CLKDIV - 1);
  localparam logic [CW-1:0] PMAX = CW'(POLLCYCLES - 1);
  localparam logic [CW-1:0] IMAX = CW'(INITCYCLES - 1);

  state_t        r_state;
  logic [DW-1:0] r_div;
  logic [6:0]    r_half;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_tx;
  logic [12:0]   r_rx;
  logic [12:0]   r_temp;
  logic [1:0]    r_sync;
  logic          r_cs_n;
  logic          r_sclk;
  logic          r_mosi;
  logic          r_valid;
  logic          w_tick;
  logic          w_end;
  logic          w_poll_wrap;
  logic          w_start;
  logic [6:0]    w_half_nx;

  // w_half_nx counts TEMPCLK half periods inside a CS window: odd = fall, even = rise, last odd = CS hold
  assign w_tick      = r_div == DMAX;
  assign w_half_nx   = r_half + 7'd1;
  assign w_end       = w_half_nx == ((r_state == RSTSEQ) ? 7'd65 : 7'd49);
  assign w_poll_wrap = r_cnt == PMAX;
  assign w_start     = (r_state == INITWAIT) ? (r_cnt == IMAX) : w_poll_wrap;

  assign nTEMPCS   = r_cs_n;
  assign TEMPCLK   = r_sclk;
  assign TEMPMOSI  = r_mosi;
  assign TEMPDATA  = r_temp;
  assign TEMPVALID = r_valid;

  // two-flop synchronizer; its latency is absorbed because MISO settles CLKDIV cycles before each rise
  always_ff @(posedge MCLK or negedge nRESET)
    if (!nRESET) r_sync <= 2'b00;
    else r_sync <= {r_sync[0], TEMPMISO};

  // sequencer plus SPI bit engine; the engine runs whenever chip select is low
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= RSTSEQ;
      r_div   <= '0;
      r_half  <= '0;
      r_cnt   <= '0;
      r_tx    <= 8'hFF;
      r_rx    <= '0;
      r_temp  <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b1;
      r_mosi  <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state inside {CMD, DATA, LATCH, POLLWAIT})
        r_cnt <= w_poll_wrap ? '0 : r_cnt + 1'b1;
      if (!r_cs_n)
        r_div <= w_tick ? '0 : r_div + 1'b1;
      if (!r_cs_n && w_tick)
        r_half <= w_half_nx;
      if (!r_cs_n && w_tick && !w_end) begin
        r_sclk <= !w_half_nx[0];
        if (w_half_nx[0]) begin
          r_mosi <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b1};
        end else if (w_half_nx <= 7'd42)
          r_rx <= {r_rx[11:0], r_sync[1]};
      end
      case (r_state)
        RSTSEQ:
          if (r_cs_n)
            r_cs_n <= 1'b0;
          else if (w_tick && w_end) begin
            r_cs_n  <= 1'b1;
            r_state <= INITWAIT;
          end
        INITWAIT, POLLWAIT:
          if (w_start) begin
            r_state <= CMD;
            r_cs_n  <= 1'b0;
            r_div   <= '0;
            r_half  <= '0;
            r_cnt   <= '0;
            r_tx    <= 8'h50;
          end else if (r_state == INITWAIT)
            r_cnt <= r_cnt + 1'b1;
        CMD:
          if (w_tick && w_half_nx == 7'd16) r_state <= DATA;
        DATA:
          if (w_tick && w_end) r_state <= LATCH;
        default: begin
          r_cs_n  <= 1'b1;
          r_temp  <= r_rx;
          r_valid <= 1'b1;
          r_state <= POLLWAIT;
        end
      endcase
    end
  end

`ifdef BUBBLEDRIVE_TEMP_ALARM_EN
  logic r_alarm;

  // hysteresis alarm, re-evaluated only when a fresh reading latches
  always_ff @(posedge MCLK or negedge nRESET)
    if (!nRESET) r_alarm <= 1'b0;
    else if (r_state == LATCH)
      r_alarm <= ($signed(r_rx) >= $signed(ALARMHI)) ? 1'b1 :
                 ($signed(r_rx) <  $signed(ALARMLO)) ? 1'b0 : r_alarm;

  assign OVERTEMP = r_alarm;
`else
  assign OVERTEMP = 1'b0;
`endif
endmodule

// File: tb/tb_adt7311_reader.sv
// tb_adt7311_reader: sensor model, SPI protocol checker and reading scoreboard for adt7311_reader
module tb_adt7311_reader;
  localparam int CLKDIV     = 12;
  localparam int POLLCYCLES = 1500;
  localparam int INITCYCLES = 600;

  logic        MCLK = 1'b0;
  logic        nRESET;
  logic        nTEMPCS;
  logic        TEMPMOSI;
  logic        TEMPMISO;
  logic        TEMPCLK;
  logic [12:0] TEMPDATA;
  logic        TEMPVALID;
  logic        OVERTEMP;

  logic [15:0] reply = 16'h0C80;
  int n_cmp = 0;
  int n_bad = 0;

  adt7311_reader #(.CLKDIV(CLKDIV), .POLLCYCLES(POLLCYCLES), .INITCYCLES(INITCYCLES)) dut (
    .MCLK(MCLK), .nRESET(nRESET), .nTEMPCS(nTEMPCS), .TEMPMOSI(TEMPMOSI), .TEMPMISO(TEMPMISO),
    .TEMPCLK(TEMPCLK), .TEMPDATA(TEMPDATA), .TEMPVALID(TEMPVALID), .OVERTEMP(OVERTEMP)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ge(input string nm, input int act, input int lo);
    n_cmp++;
    if (act < lo) begin
      n_bad++;
      $display("FAIL %s: got %0d, required >= %0d", nm, act, lo);
    end
  endtask

  // sensor: after the command byte, drive the 16-bit reply MSB first on TEMPCLK falls
  int          s_falls = 0;
  logic        s_pclk  = 1'b1;
  logic [15:0] s_word  = '0;
  initial begin
    TEMPMISO = 1'b1;
    forever begin
      @(negedge MCLK);
      if (nTEMPCS) s_falls = 0;
      else if (s_pclk && !TEMPCLK) begin
        s_falls++;
        if (s_falls == 9) s_word = reply;
        if (s_falls >= 9 && s_falls <= 24) TEMPMISO = s_word[24 - s_falls];
      end
      s_pclk = TEMPCLK;
    end
  end

  // model and compare: each CS window must be the 32-ones reset or a 0x50 read; a read's CS rise carries the new word
  logic        pcs = 1'b1, pclk = 1'b1, pmosi = 1'b1, fell, rose, first_edge = 1'b0;
  logic        exp_v, exp_a = 1'b0;
  logic [12:0] exp_t = '0;
  logic [15:0] cur = '0;
  logic [31:0] mbits = '0;
  int cyc = 0, rises = 0, nwin = 0, t_edge = 0, t_fall = 0, t_rise = 0, t_csr = 0, t_cmd = 0;
  initial forever begin
    @(negedge MCLK);
    cyc++;
    exp_v = 1'b0;
    if (!nRESET) begin
      chk("reset_nTEMPCS", nTEMPCS, 1);
      chk("reset_TEMPCLK", TEMPCLK, 1);
      chk("reset_TEMPMOSI", TEMPMOSI, 1);
      chk("reset_TEMPVALID", TEMPVALID, 0);
      chk("reset_TEMPDATA", TEMPDATA, 0);
      chk("reset_OVERTEMP", OVERTEMP, 0);
      exp_t = '0;
      exp_a = 1'b0;
      nwin = 0;
      first_edge = 1'b0;
    end else begin
      fell = pclk && !TEMPCLK;
      rose = !pclk && TEMPCLK;
      if (nTEMPCS) chk("sclk_idle_high", TEMPCLK, 1);
      if (TEMPMOSI !== pmosi) chk("mosi_changes_on_fall", fell, 1);
      if (fell || rose) begin
        if (first_edge) chk_ge("cs_setup", cyc - t_fall, CLKDIV);
        else chk("half_period", cyc - t_edge, CLKDIV);
        first_edge = 1'b0;
        t_edge = cyc;
      end
      if (rose) begin
        rises++;
        mbits = {mbits[30:0], TEMPMOSI};
        t_rise = cyc;
      end
      if (pcs && !nTEMPCS) begin
        if (nwin >= 1) chk_ge("cs_gap", cyc - t_csr, nwin == 1 ? INITCYCLES : 2 * CLKDIV);
        if (nwin >= 2) chk("poll_period", cyc - t_cmd, POLLCYCLES);
        t_cmd = cyc;
        t_fall = cyc;
        rises = 0;
        first_edge = 1'b1;
        cur = reply;
      end
      if (!pcs && nTEMPCS) begin
        chk_ge("cs_hold", cyc - t_rise, CLKDIV);
        if (nwin == 0) begin
          chk("rstseq_bits", rises, 32);
          chk("rstseq_mosi", mbits, 32'hFFFF_FFFF);
        end else begin
          chk("read_bits", rises, 24);
          chk("cmd_byte", mbits[23:16], 8'h50);
          exp_t = cur[15:3];
          exp_v = 1'b1;
`ifdef BUBBLEDRIVE_TEMP_ALARM_EN
          if ($signed(exp_t) >= 13'sd1120) exp_a = 1'b1;
          else if ($signed(exp_t) < 13'sd1040) exp_a = 1'b0;
`endif
        end
        nwin++;
        t_csr = cyc;
      end
      chk("TEMPVALID", TEMPVALID, exp_v);
      chk("TEMPDATA", TEMPDATA, exp_t);
      chk("OVERTEMP", OVERTEMP, exp_a);
    end
    pcs = nTEMPCS;
    pclk = TEMPCLK;
    pmosi = TEMPMOSI;
  end

  task automatic wait_valid();
    int n = 0;
    while (!TEMPVALID && n < 4000) begin
      @(negedge MCLK);
      n++;
    end
    chk("valid_within_budget", TEMPVALID, 1);
  endtask

  logic [15:0] tbl   [5] = '{16'h0C80, 16'hE700, 16'h2300, 16'h2260, 16'h2078};
  logic [12:0] lit_t [5] = '{13'h0190, 13'h1CE0, 13'h0460, 13'h044C, 13'h040F};
`ifdef BUBBLEDRIVE_TEMP_ALARM_EN
  logic        lit_a [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
  logic        lit_a [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

  // directed sequence: reset, five readings, reset mid-read, recovery reading
  initial begin
    int n, nf, nr;
    logic pc;
    nRESET = 1'b0;
    repeat (3) @(negedge MCLK);
    chk("lit_reset_TEMPDATA", TEMPDATA, 13'h0000);
    chk("lit_reset_nTEMPCS", nTEMPCS, 1'b1);
    nRESET = 1'b1;
    for (int i = 0; i < 5; i++) begin
      reply = tbl[i];
      wait_valid();
      chk("lit_TEMPDATA", TEMPDATA, lit_t[i]);
      chk("lit_OVERTEMP", OVERTEMP, lit_a[i]);
      @(negedge MCLK);
      chk("lit_valid_one_cycle", TEMPVALID, 1'b0);
    end
    reply = 16'h7FF8;
    n = 0;
    while (nTEMPCS && n < 4000) begin
      @(negedge MCLK);
      n++;
    end
    chk("abort_window_open", nTEMPCS, 1'b0);
    nf = 0;
    n = 0;
    pc = TEMPCLK;
    while (nf < 17 && n < 2000) begin
      @(negedge MCLK);
      if (pc && !TEMPCLK) nf++;
      pc = TEMPCLK;
      n++;
    end
    chk("abort_at_data_bit7", nf, 17);
    repeat (4) @(negedge MCLK);
    nRESET = 1'b0;
    #1;
    chk("abort_cs_high", nTEMPCS, 1'b1);
    chk("abort_sclk_high", TEMPCLK, 1'b1);
    @(posedge MCLK);
    #1;
    chk("abort_TEMPDATA", TEMPDATA, 13'h0000);
    chk("abort_TEMPVALID", TEMPVALID, 1'b0);
    repeat (2) @(negedge MCLK);
    nRESET = 1'b1;
    reply = 16'h1238;
    n = 0;
    while (nTEMPCS && n < 100) begin
      @(negedge MCLK);
      n++;
    end
    nr = 0;
    n = 0;
    pc = TEMPCLK;
    while (!nTEMPCS && n < 2000) begin
      @(negedge MCLK);
      if (!pc && TEMPCLK) nr++;
      pc = TEMPCLK;
      n++;
    end
    chk("rerun_rstseq_bits", nr, 32);
    wait_valid();
    chk("lit_recovery_TEMPDATA", TEMPDATA, 13'h0247);
    repeat (5) @(negedge MCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adt7311_reader.md
ADT7311_READER -- requirements
Module: adt7311_reader

Interface
REQ-001 SHALL have parameter CLKDIV, default 12, meaning MCLK cycles per TEMPCLK half-period (2 MHz SCLK at 48 MHz).
REQ-002 SHALL have parameter POLLCYCLES, default 4800000, meaning MCLK cycles from one conversion read start to the next (100 ms).
REQ-003 SHALL have parameter INITCYCLES, default 24000, meaning MCLK cycles of wait after the sensor reset sequence (500 us).
REQ-004 SHALL have parameter ALARMHI, default 13'd1120, meaning the OVERTEMP set threshold in 0.0625 C LSB (70 C).
REQ-005 SHALL have parameter ALARMLO, default 13'd1040, meaning the OVERTEMP clear threshold (65 C).
REQ-006 MCLK  input  1  sole clock, 48 MHz, rising edge.
REQ-007 nRESET  input  1  asynchronous active-low reset.
REQ-008 nTEMPCS  output  1  ADT7311 chip select, active low.
REQ-009 TEMPMOSI  output  1  serial data to sensor DIN.
REQ-010 TEMPMISO  input  1  serial data from sensor DOUT.
REQ-011 TEMPCLK  output  1  SPI clock, mode 3 (idle high).
REQ-012 TEMPDATA  output  13  last signed temperature word, two's complement, 0.0625 C/LSB.
REQ-013 TEMPVALID  output  1  one-MCLK pulse when TEMPDATA updates.
REQ-014 OVERTEMP  output  1  level alarm for LEDDriver.

Function
REQ-015 FSM states SHALL be RSTSEQ, INITWAIT, POLLWAIT, CMD, DATA, LATCH; exit from reset enters RSTSEQ.
REQ-016 RSTSEQ SHALL hold nTEMPCS low and shift 32 bits of 1 on TEMPMOSI, then raise nTEMPCS and go to INITWAIT.
REQ-017 INITWAIT SHALL count INITCYCLES MCLK cycles, then go to CMD.
REQ-018 CMD SHALL drive nTEMPCS low and shift command byte 8'h50 (read register 0x02) MSB first.
REQ-019 DATA SHALL follow CMD without deasserting nTEMPCS and shift in 16 bits MSB first.
REQ-020 LATCH SHALL raise nTEMPCS, load TEMPDATA with received bits [15:3], pulse TEMPVALID for exactly one cycle, and go to POLLWAIT.
REQ-021 POLLWAIT SHALL return to CMD when a free-running POLLCYCLES counter, started at CMD entry, wraps; period from one CMD entry to the next = POLLCYCLES exactly.
REQ-022 TEMPCLK SHALL toggle every CLKDIV MCLK cycles only while nTEMPCS is low; TEMPMOSI SHALL change on TEMPCLK falling edges; TEMPMISO SHALL be sampled on the MCLK cycle TEMPCLK rises.
REQ-023 nTEMPCS SHALL fall at least CLKDIV cycles before the first TEMPCLK fall and rise at least CLKDIV cycles after the last TEMPCLK rise.
REQ-024 nTEMPCS SHALL stay high for at least 2*CLKDIV cycles between any two transactions.
REQ-025 TEMPMISO SHALL pass through a two-flop synchronizer; sample timing SHALL compensate its 2-cycle latency (CLKDIV >= 4).
REQ-026 TEMPDATA SHALL hold its value between LATCH events; a transaction cut short by reset SHALL not update TEMPDATA.
REQ-027 Temperature comparisons SHALL be signed 13-bit.

Reset
REQ-028 On nRESET low: nTEMPCS=1, TEMPCLK=1, TEMPMOSI=1, TEMPDATA=0, TEMPVALID=0, OVERTEMP=0, all counters 0, state RSTSEQ.
REQ-029 Reset assertion mid-transaction SHALL abort immediately; release SHALL restart with the full RSTSEQ.

Configuration
REQ-030 With macro BUBBLEDRIVE_TEMP_ALARM_EN defined: OVERTEMP SHALL set at LATCH when the new TEMPDATA >= ALARMHI and clear at LATCH when < ALARMLO, holding otherwise (hysteresis).
REQ-031 Without BUBBLEDRIVE_TEMP_ALARM_EN: OVERTEMP SHALL be constant 0 and no comparator logic SHALL exist.

Verification
REQ-032 Reset release, sensor model -> TEMPMOSI 32 ones in one nTEMPCS-low window, then nTEMPCS high >= 24000 cycles before byte 8'h50.
REQ-033 Model returns 16'h0C80 -> TEMPDATA=13'h0190 (25 C), one TEMPVALID pulse, next CMD exactly 4800000 cycles after previous CMD entry.
REQ-034 Model returns 16'hE700 (negative) -> TEMPDATA=13'h1CE0, OVERTEMP stays 0.
REQ-035 Alarm build, readings 1120, 1100, 1039 -> OVERTEMP 1, 1, 0 after respective LATCH.
REQ-036 nRESET pulsed low during DATA bit 7 -> nTEMPCS high and TEMPCLK high next edge, TEMPDATA=0, RSTSEQ re-runs.
REQ-037 SPI checker across all transactions -> TEMPCLK period 24 cycles, MOSI stable at every rising edge, CS setup/hold/gap per REQ-023/024.
